// File: rtl/fd_pkg.sv
// Shared definitions for the forward-difference / divergence pipeline:
// default geometry, the frame-sequencing state enum and a saturating subtract.
`timescale 1ns/1ps
package fd_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;
    localparam int DEF_ADDRW = 12;

    // Widest operand sat_sub() handles; callers sign-extend into this width.
    localparam int SAT_MAXW = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } fd_state_t;

    // a - b evaluated one bit wider than the operands, then clamped to the
    // signed range of a w-bit result. The result sits in the low w bits.
    function automatic logic signed [SAT_MAXW-1:0] sat_sub(
        input logic signed [SAT_MAXW-1:0] a,
        input logic signed [SAT_MAXW-1:0] b,
        input int unsigned                w
    );
        logic signed [SAT_MAXW:0] diff;
        logic signed [SAT_MAXW:0] hi;
        logic signed [SAT_MAXW:0] lo;
        diff = {a[SAT_MAXW-1], a} - {b[SAT_MAXW-1], b};
        hi   = ({{SAT_MAXW{1'b0}}, 1'b1} << (w - 1)) - {{SAT_MAXW{1'b0}}, 1'b1};
        lo   = ~hi;
        if (diff > hi) begin
            return hi[SAT_MAXW-1:0];
        end else if (diff < lo) begin
            return lo[SAT_MAXW-1:0];
        end
        return diff[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/fd_line_delay.sv
// One image row of delay: DEPTH x WIDTH shift register with enable.
// tap_last is the oldest sample (d[DEPTH-1]), tap_prev the one after it (d[DEPTH-2]).
`timescale 1ns/1ps
module fd_line_delay #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap_last,
    output logic [WIDTH-1:0] tap_prev
);

    logic [WIDTH-1:0] d [DEPTH];

    // Shift one position per enabled cycle, newest sample into d[0].
    // NOTE: no reset on the delay line; every entry is overwritten during FILL
    // before it is read, and a reset here would stop RAM/SRL inference.
    // NOTE: non-blocking assignments make every stage read its neighbour's old value.
    always_ff @(posedge i_clk) begin
        if (en) begin
            d[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                d[i] <= d[i-1];
            end
        end
    end

    assign tap_last = d[DEPTH-1];
    assign tap_prev = d[DEPTH-2];

endmodule

// File: rtl/grad2d_stream.sv
// Streaming forward-difference gradient: Ux = u(r,c+1)-u(r,c), Uy = u(r+1,c)-u(r,c),
// Neumann boundary (last column Ux=0, last row Uy=0), saturated, with raster address.
`timescale 1ns/1ps
module grad2d_stream
    import fd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int ADDRW = DEF_ADDRW
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dx,
    output logic [WIDTH-1:0] o_dy,
    output logic [ADDRW-1:0] o_addr,
    output logic             o_busy,
    output logic             o_done
);

    localparam int NPIX = IMG_W * IMG_H;
    // IMG_W*IMG_H is a power of two, so IMG_W is too and the column is the low address bits.
    localparam int CW = $clog2(IMG_W);
    localparam logic [ADDRW-1:0] LAST_FILL = ADDRW'(IMG_W - 1);
    localparam logic [ADDRW-1:0] LAST_PIX  = ADDRW'(NPIX - 1);
    localparam logic [ADDRW-1:0] ONE       = ADDRW'(1);

    fd_state_t state;
    logic [ADDRW-1:0] in_cnt;     // pixels accepted so far in this frame
    logic [ADDRW-1:0] out_addr;   // address of the next output pixel

    logic             accept;
    logic             shift_en;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] tap_last;
    logic [WIDTH-1:0] tap_prev;
    logic             last_col;
    logic signed [SAT_MAXW-1:0] dx_full;
    logic signed [SAT_MAXW-1:0] dy_full;
    logic [WIDTH-1:0] dx_sat;
    logic [WIDTH-1:0] dy_sat;

    fd_line_delay #(
        .DEPTH (IMG_W),
        .WIDTH (WIDTH)
    ) u_line (
        .i_clk    (i_clk),
        .en       (shift_en),
        .din      (shift_in),
        .tap_last (tap_last),
        .tap_prev (tap_prev)
    );

    // Handshake, delay-line control and the saturated, boundary-masked differences.
    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    always_comb begin
        accept   = i_valid & o_ready;
        shift_en = accept | (state == ST_FLUSH);
        shift_in = (state == ST_FLUSH) ? '0 : i_data;
        last_col = (out_addr[CW-1:0] == CW'(IMG_W - 1));
        dx_full  = sat_sub(SAT_MAXW'(signed'(tap_prev)), SAT_MAXW'(signed'(tap_last)), WIDTH);
        dy_full  = sat_sub(SAT_MAXW'(signed'(i_data)),   SAT_MAXW'(signed'(tap_last)), WIDTH);
        dx_sat   = last_col ? '0 : dx_full[WIDTH-1:0];
        dy_sat   = dy_full[WIDTH-1:0];
    end

    // Frame sequencer with registered outputs: FILL primes one row, STREAM emits one
    // output per accepted pixel, FLUSH drains the last row, DONE pulses o_done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            in_cnt   <= '0;
            out_addr <= '0;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_dx     <= '0;
            o_dy     <= '0;
            o_addr   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state    <= ST_FILL;
                        o_ready  <= 1'b1;
                        o_busy   <= 1'b1;
                        in_cnt   <= '0;
                        out_addr <= '0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        in_cnt <= in_cnt + ONE;
                        if (in_cnt == LAST_FILL) begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        in_cnt   <= in_cnt + ONE;
                        o_valid  <= 1'b1;
                        o_dx     <= dx_sat;
                        o_dy     <= dy_sat;
                        o_addr   <= out_addr;
                        out_addr <= out_addr + ONE;
                        if (in_cnt == LAST_PIX) begin
                            state   <= ST_FLUSH;
                            o_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Last image row: no row below, so Uy is zero.
                    o_valid <= 1'b1;
                    o_dx    <= dx_sat;
                    o_dy    <= '0;
                    o_addr  <= out_addr;
                    if (out_addr == LAST_PIX) begin
                        state <= ST_DONE;
                    end else begin
                        out_addr <= out_addr + ONE;
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
